mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Memory access controller sitting directly downstream of the memory address register. It captures a 13-bit address and optional write data, runs a req/ack handshake with main memory, and holds read data in an internal memory data register. It reports busy/done/error so the control unit can sequence fetch and load/store cycles.

## Interface
- ADDR_W, 13, address width; matches the MAR output.
- DATA_W, 16, data word width.
- TIMEOUT_CYC, 15, maximum cycles to wait for mem_ack. Used only with MEM_TIMEOUT_EN; legal range 1..255.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_rd  in  1  request a read; sampled in IDLE only.
- start_wr  in  1  request a write; sampled in IDLE only.
- addr_in  in  ADDR_W  access address, from MARout.
- wdata_in  in  DATA_W  write data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when an access completes.
- err  out  1  one-cycle pulse on timeout. Constant 0 without MEM_TIMEOUT_EN.
- rdata_out  out  DATA_W  memory data register. Holds its value until the next completed read.
- mem_req  out  1  memory request; held until the access completes.
- mem_we  out  1  write strobe; qualified by mem_req.
- mem_addr  out  ADDR_W  registered address.
- mem_wdata  out  DATA_W  registered write data.
- mem_ack  in  1  memory acknowledge; read data is valid in the same cycle.
- mem_rdata  in  DATA_W  memory read data.

## Operation
- States: IDLE, ACCESS, DONE, and ERR (ERR exists only with MEM_TIMEOUT_EN).
- IDLE, start_rd or start_wr high:
  - latch addr_in into mem_addr and wdata_in into mem_wdata;
  - set mem_we = start_wr && !start_rd;
  - go to ACCESS.
- If start_rd and start_wr are both high, the read wins and no write is performed.
- ACCESS: mem_req is high.
  - On mem_ack: a read loads mem_rdata into rdata_out; state goes to DONE.
  - A write leaves rdata_out unchanged.
- DONE: done = 1 for exactly one cycle, then IDLE. start_* is ignored in DONE.
- start_* is ignored in ACCESS, DONE and ERR. No queuing.
- mem_ack is ignored outside ACCESS.
- mem_addr, mem_wdata and mem_we are stable for the whole ACCESS state.
- Reset values: state = IDLE, every output 0, rdata_out = 0, mem_addr = 0, mem_wdata = 0.
- Reset mid-access aborts the access. mem_req drops asynchronously, and no done or err pulse is produced.

## Timing
- Outputs are registered; there is no combinational path from any input to any output.
- Start sampled at edge E0: mem_req is high from E0 to the completing edge, busy is high from E0.
- mem_ack high in the cycle ending at edge En:
  - mem_req falls at En;
  - rdata_out updates at En;
  - done is high from En to En+1;
  - busy falls at En+1.
- Minimum access (ack in the first ACCESS cycle): start to done takes 2 cycles; start to next accepted start takes 3 cycles.
- Back-to-back accesses: a new start is accepted in the cycle after done.

## Configuration
- MEM_TIMEOUT_EN defined:
  - an 8-bit wait counter clears on entry to ACCESS and increments each ACCESS cycle without mem_ack;
  - when the counter reaches TIMEOUT_CYC without an ack, the block goes to ERR: mem_req drops, err pulses for one cycle, rdata_out is unchanged, then IDLE;
  - an ack arriving in the same cycle as the limit is reached wins over the timeout.
- MEM_TIMEOUT_EN undefined:
  - no counter and no ERR state;
  - err is tied to 0;
  - ACCESS waits for mem_ack indefinitely.

## Structure
- Shared package `proc_pkg` holds:
  - ADDR_W and DATA_W defaults, shared with the MAR and the datapath;
  - the state encoding constants ST_IDLE, ST_ACCESS, ST_DONE, ST_ERR (2-bit).
- One sub-module, `mem_timeout_cnt` (the wait counter plus limit compare), instantiated only under MEM_TIMEOUT_EN.
- Everything else is a single FSM in mem_access_ctrl.

## Test plan
- Reset then read: start_rd with addr 0x1A3; memory acks on the 3rd ACCESS cycle with 0xBEEF. Required: mem_addr = 0x1A3, mem_we = 0, rdata_out = 0xBEEF, one done pulse, busy for 4 cycles.
- Write: start_wr with addr 0x0FF and data 0x1234; ack after 1 cycle. Required: mem_we = 1, mem_wdata = 0x1234, one done pulse, rdata_out unchanged.
- Simultaneous start_rd + start_wr at addr 0x010. Required: a read is performed (mem_we = 0) and no write occurs.
- start_rd toggled during ACCESS, and mem_ack pulsed in IDLE. Required: ignored, with exactly one access and one done.
- rst asserted mid-ACCESS. Required: mem_req, busy, done and rdata_out are 0 immediately; no done pulse; a new read after release works.
- With MEM_TIMEOUT_EN and TIMEOUT_CYC = 4, no ack:
  - required: err pulses after 4 ACCESS cycles, no done pulse, return to IDLE;
  - with the ack arriving in the 4th cycle instead: done pulses and err does not.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared processor definitions: datapath widths and the
// memory access controller state encoding.
package proc_pkg;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2,
        ST_ERR    = 2'd3
    } state_t;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Wait counter for the memory handshake; flags the cycle in which
// the limit is reached without an acknowledge.
module mem_timeout_cnt #(
    parameter logic [7:0] LIMIT = 8'd15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_hit
);

    logic [7:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 8'd0;
        end else if (i_clr) begin
            r_cnt <= 8'd0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // r_cnt counts completed idle cycles, so this one is number LIMIT
    assign o_hit = i_inc && (r_cnt == LIMIT - 8'd1);

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller: req/ack handshake plus memory data register.
// Define MEM_TIMEOUT_EN to add the ack timeout and the ERR state.
module mem_access_ctrl #(
    parameter int ADDR_W      = proc_pkg::ADDR_W,
    parameter int DATA_W      = proc_pkg::DATA_W,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_rd,
    input  logic              start_wr,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata_out,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    import proc_pkg::*;

    state_t r_state;
    state_t w_next;
    logic   w_start;
    logic   w_timeout;

    assign w_start = start_rd || start_wr;

`ifdef MEM_TIMEOUT_EN
    mem_timeout_cnt #(
        .LIMIT (8'(TIMEOUT_CYC))
    ) u_timeout (
        .clk   (clk),
        .rst   (rst),
        .i_clr (r_state != ST_ACCESS),
        .i_inc ((r_state == ST_ACCESS) && !mem_ack),
        .o_hit (w_timeout)
    );

    assign err = (r_state == ST_ERR);
`else
    // The limit has no effect when the timeout is compiled out
    logic [7:0] w_unused_timeout;
    assign w_unused_timeout = 8'(TIMEOUT_CYC);
    assign w_timeout        = 1'b0;
    assign err              = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (mem_ack) begin
                    w_next = ST_DONE;
                end else if (w_timeout) begin
                    w_next = ST_ERR;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            ST_ERR:  w_next = ST_IDLE;
        endcase
    end

    // Request bundle is only loaded in IDLE, so it is frozen across ACCESS
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            rdata_out <= '0;
        end else begin
            if (r_state == ST_IDLE && w_start) begin
                mem_addr  <= addr_in;
                mem_wdata <= wdata_in;
                mem_we    <= start_wr && !start_rd;
            end
            if (r_state == ST_ACCESS && mem_ack && !mem_we) begin
                rdata_out <= mem_rdata;
            end
        end
    end

    assign busy    = (r_state != ST_IDLE);
    assign done    = (r_state == ST_DONE);
    assign mem_req = (r_state == ST_ACCESS);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl; build with MEM_TIMEOUT_EN
// defined to also exercise the timeout path (TIMEOUT_CYC = 4).
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst;
    logic        start_rd;
    logic        start_wr;
    logic [12:0] addr_in;
    logic [15:0] wdata_in;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] rdata_out;
    logic        mem_req;
    logic        mem_we;
    logic [12:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    int n_run;
    int n_fail;
    int n_done;
    int n_err;
    int n_busy;

    mem_access_ctrl #(
        .ADDR_W      (13),
        .DATA_W      (16),
        .TIMEOUT_CYC (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_rd  (start_rd),
        .start_wr  (start_wr),
        .addr_in   (addr_in),
        .wdata_in  (wdata_in),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata_out (rdata_out),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (done) n_done++;
        if (err)  n_err++;
        if (busy) n_busy++;
    endtask

    task automatic clr_cnt();
        n_done = 0;
        n_err  = 0;
        n_busy = 0;
    endtask

    task automatic start(input logic rd, input logic wr,
                         input logic [12:0] a, input logic [15:0] d);
        start_rd = rd;
        start_wr = wr;
        addr_in  = a;
        wdata_in = d;
        tick();
        start_rd = 1'b0;
        start_wr = 1'b0;
    endtask

    task automatic ack(input logic [15:0] d);
        mem_ack   = 1'b1;
        mem_rdata = d;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 16'h0;
    endtask

    initial begin
        n_run = 0;
        n_fail = 0;
        clr_cnt();
        rst = 1'b1;
        start_rd = 1'b0;
        start_wr = 1'b0;
        addr_in = '0;
        wdata_in = '0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_rdata", rdata_out, 0);
        rst = 1'b0;
        tick();

        // read, ack on the third ACCESS cycle
        clr_cnt();
        start(1'b1, 1'b0, 13'h1A3, 16'h9999);
        chk("rd_req", mem_req, 1);
        chk("rd_addr", mem_addr, 13'h1A3);
        chk("rd_we", mem_we, 0);
        tick();
        tick();
        chk("rd_req_hold", mem_req, 1);
        ack(16'hBEEF);
        chk("rd_done", done, 1);
        chk("rd_req_fall", mem_req, 0);
        chk("rd_rdata", rdata_out, 16'hBEEF);
        tick();
        chk("rd_idle", busy, 0);
        tick();
        chk("rd_ndone", n_done, 1);
        chk("rd_nbusy", n_busy, 4);

        // write, minimum latency
        clr_cnt();
        start(1'b0, 1'b1, 13'h0FF, 16'h1234);
        chk("wr_we", mem_we, 1);
        chk("wr_wdata", mem_wdata, 16'h1234);
        chk("wr_addr", mem_addr, 13'h0FF);
        ack(16'hAAAA);
        chk("wr_done", done, 1);
        chk("wr_rdata", rdata_out, 16'hBEEF);
        tick();
        chk("wr_ndone", n_done, 1);
        chk("wr_nbusy", n_busy, 2);

        // back-to-back: start in the cycle after done
        clr_cnt();
        start(1'b1, 1'b1, 13'h010, 16'h5555);
        chk("both_busy", busy, 1);
        chk("both_we", mem_we, 0);
        chk("both_addr", mem_addr, 13'h010);
        ack(16'h0A0A);
        chk("both_rdata", rdata_out, 16'h0A0A);
        tick();
        chk("both_ndone", n_done, 1);

        // start toggled in ACCESS and DONE, ack pulsed in IDLE
        clr_cnt();
        start(1'b1, 1'b0, 13'h020, 16'h0);
        start_rd = 1'b1;
        addr_in  = 13'h1FF;
        tick();
        start_rd = 1'b0;
        tick();
        start_wr = 1'b1;
        tick();
        start_wr = 1'b0;
        chk("ign_addr", mem_addr, 13'h020);
        chk("ign_we", mem_we, 0);
        ack(16'h7777);
        start_wr = 1'b1;
        tick();
        start_wr = 1'b0;
        chk("ign_done_start", busy, 0);
        mem_ack   = 1'b1;
        mem_rdata = 16'hDEAD;
        tick();
        tick();
        mem_ack   = 1'b0;
        chk("ign_ack_busy", busy, 0);
        chk("ign_rdata", rdata_out, 16'h7777);
        chk("ign_ndone", n_done, 1);

        // reset in the middle of an access
        clr_cnt();
        start(1'b1, 1'b0, 13'h033, 16'h0);
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("mid_req", mem_req, 0);
        chk("mid_busy", busy, 0);
        chk("mid_done", done, 0);
        chk("mid_rdata", rdata_out, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("mid_ndone", n_done, 0);
        start(1'b1, 1'b0, 13'h044, 16'h0);
        chk("mid_addr", mem_addr, 13'h044);
        ack(16'h4242);
        chk("mid_rdata2", rdata_out, 16'h4242);
        tick();

`ifdef MEM_TIMEOUT_EN
        // no ack: err after four ACCESS cycles
        clr_cnt();
        start(1'b1, 1'b0, 13'h055, 16'h0);
        begin
            int k;
            k = 0;
            while (!err && k < 20) begin
                tick();
                k++;
            end
            chk("to_cycles", k, 4);
        end
        chk("to_err", err, 1);
        chk("to_req", mem_req, 0);
        chk("to_rdata", rdata_out, 16'h4242);
        tick();
        chk("to_idle", busy, 0);
        chk("to_ndone", n_done, 0);
        chk("to_nerr", n_err, 1);

        // ack in the cycle the limit is reached
        clr_cnt();
        start(1'b1, 1'b0, 13'h066, 16'h0);
        tick();
        tick();
        tick();
        ack(16'h6666);
        chk("race_done", done, 1);
        chk("race_err", err, 0);
        chk("race_rdata", rdata_out, 16'h6666);
        tick();
        chk("race_nerr", n_err, 0);
`else
        // no timeout: a long wait still completes normally
        clr_cnt();
        start(1'b1, 1'b0, 13'h055, 16'h0);
        repeat (20) tick();
        chk("wait_req", mem_req, 1);
        chk("wait_nerr", n_err, 0);
        ack(16'h5A5A);
        chk("wait_done", done, 1);
        chk("wait_rdata", rdata_out, 16'h5A5A);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
